xc_rf_wb: RTL and testbench
===========================

XC_RF_WB -- requirements
Module: xc_rf_wb

Interface
REQ-001 SHALL have parameter WIDE_EN, default 1: 1 = attached register file accepts double-width writes; 0 = wide results split into two single writes.
REQ-002 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-004 SHALL have ports a_valid input 1, a_ready output 1, a_wide input 1, a_addr input 5, a_wdata input 32, a_wdata_hi input 32: result channel A.
REQ-005 SHALL have ports b_valid, b_ready, b_wide, b_addr, b_wdata, b_wdata_hi with identical widths and meaning: result channel B.
REQ-006 SHALL have ports rd_wen output 1, rd_wide output 1, rd_addr output 5, rd_wdata output 32, rd_wdata_hi output 32: register-file write port, all registered.
REQ-007 SHALL have port err output 1: one-cycle pulse on a rejected request.
REQ-008 SHALL have port busy output 1: high while in state SPLIT_HI or while rd_wen is high.

Function
REQ-009 A channel transfer SHALL occur on a rising edge where x_valid and x_ready are both high.
REQ-010 x_ready SHALL be combinational: high only in state IDLE and only for the channel granted this cycle.
REQ-011 Arbitration SHALL be round-robin: one valid channel gets the grant; both valid -> grant goes to the channel not granted last; last-grant bit updates on every transfer.
REQ-012 Last-grant bit SHALL reset to B, so channel A wins the first tie.
REQ-013 Accepted narrow request SHALL drive rd_wen=1, rd_wide=0, rd_addr=addr, rd_wdata=wdata on the next cycle, for exactly one cycle.
REQ-014 Wide request with addr[0]=1 SHALL be consumed (ready high), produce no write, and pulse err the next cycle.
REQ-015 With WIDE_EN=1, accepted wide request with even addr SHALL drive rd_wen=1, rd_wide=1, rd_addr=addr, rd_wdata=wdata, rd_wdata_hi=wdata_hi next cycle, for one cycle.
REQ-016 With WIDE_EN=0, accepted wide request with even addr SHALL write {addr, wdata} next cycle, enter SPLIT_HI, and the following cycle write {addr|1, wdata_hi}, rd_wide=0, then return to IDLE.
REQ-017 FSM SHALL have states IDLE and SPLIT_HI only; SPLIT_HI lasts exactly one cycle and deasserts both readys.
REQ-018 Writes to addr 0 SHALL be forwarded unchanged; suppression is the register file's job.
REQ-019 rd_wide SHALL never be 1 when WIDE_EN=0.
REQ-020 Throughput SHALL be one narrow or native-wide write per cycle when valids stay high.
REQ-021 rd_wdata_hi SHALL be 0 whenever rd_wide=0.

Reset
REQ-022 While resetn=0 at a clock edge: state=IDLE, last-grant=B, rd_wen=0, rd_wide=0, rd_addr=0, rd_wdata=0, rd_wdata_hi=0, err=0.
REQ-023 Reset in SPLIT_HI SHALL abandon the pending high write; no write SHALL issue after reset.
REQ-024 a_ready and b_ready SHALL be 0 while resetn=0.

Structure
REQ-025 State encodings and the 5-bit register-address width SHALL live in a shared package used by xc_rf_wb and the register-file blocks.
REQ-026 Arbitration SHALL be a sub-module xc_rr_arb2: two requests in, one-hot grant out, last-grant register updated on a transfer strobe.
REQ-027 Output write register and FSM SHALL stay in xc_rf_wb; no other sub-modules.

Verification
REQ-028 A narrow addr 5, wdata 0x1234_5678, B idle -> next cycle rd_wen=1, rd_addr=5, rd_wdata=0x1234_5678, rd_wide=0, a_ready=1 at accept.
REQ-029 A and B valid together for 4 cycles after reset -> grants A,B,A,B; four consecutive rd_wen pulses.
REQ-030 WIDE_EN=1, B wide addr 6, lo 0xAAAA_0000, hi 0xBBBB_1111 -> one cycle rd_wide=1, rd_addr=6, rd_wdata_hi=0xBBBB_1111.
REQ-031 WIDE_EN=0, same request -> write {6, 0xAAAA_0000} then {7, 0xBBBB_1111}; both readys low during SPLIT_HI; busy high both cycles.
REQ-032 Wide addr 3 -> consumed, err pulses once, rd_wen stays 0.
REQ-033 WIDE_EN=0, resetn low during SPLIT_HI -> no write to addr 7; all outputs 0 after reset edge.

Source files
------------

// File: rtl/xc_rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xc_rf_wb_pkg
// Description : Shared definitions for the register-file writeback slice.
//               It defines the register-address and data widths and the
//               writeback FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package xc_rf_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    SPLIT_HI = 1'b1
  } wb_state_t;

endpackage : xc_rf_wb_pkg
`default_nettype wire

// File: rtl/xc_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : xc_rr_arb2
// Description : Two-requester round-robin arbiter. It produces a one-hot grant
//               and keeps a last-grant register that updates on each transfer.
// Ports       : clock  - sole clock
//               resetn - synchronous active-low reset (last-grant -> B)
//               req    - request vector, bit0 = A, bit1 = B
//               xfer   - a transfer happened this cycle on the granted channel
//               grant  - one-hot grant (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module xc_rr_arb2 (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       xfer,
  output logic [1:0] grant
);

  // 1 = B was granted last. Resetting to B lets A win the first tie.
  logic last_b;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_b ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      last_b <= 1'b1;
    end else if (xfer) begin
      last_b <= grant[1];
    end
  end

endmodule : xc_rr_arb2
`default_nettype wire

// File: rtl/xc_rf_wb.sv
`default_nettype none
// ============================================================================
// Module      : xc_rf_wb
// Description : Register-file writeback merger. It arbitrates two result
//               channels onto one registered register-file write port. Wide
//               results go out either natively (WIDE_EN=1) or as two narrow
//               writes to addr and addr|1 (WIDE_EN=0). A wide request to an
//               odd address is consumed and flagged on err.
// Ports       : clock, resetn                        - clock, sync active-low reset
//               a_valid/a_ready/a_wide/a_addr/
//               a_wdata/a_wdata_hi                   - result channel A
//               b_*                                  - result channel B
//               rd_wen/rd_wide/rd_addr/rd_wdata/
//               rd_wdata_hi                          - registered write port
//               err                                  - one-cycle reject pulse
//               busy                                 - split pending or write out
// Revision    : 1.0 - initial release
// ============================================================================
module xc_rf_wb
  import xc_rf_wb_pkg::*;
#(
  parameter int WIDE_EN = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_wide,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic [DATA_W-1:0]     a_wdata_hi,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_wide,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  input  logic [DATA_W-1:0]     b_wdata_hi,
  output logic                  rd_wen,
  output logic                  rd_wide,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_wdata,
  output logic [DATA_W-1:0]     rd_wdata_hi,
  output logic                  err,
  output logic                  busy
);

  wb_state_t state, state_nxt;

  logic [1:0]            grant;
  logic                  accept;
  logic                  sel_wide;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [DATA_W-1:0]     sel_wdata_hi;

  // High half of a split write. The low address bit is implied (always 1).
  logic [REG_ADDR_W-1:1] pend_addr;
  logic [DATA_W-1:0]     pend_hi;

  logic                  wen_nxt;
  logic                  wide_nxt;
  logic [REG_ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0]     wdata_nxt;
  logic [DATA_W-1:0]     wdata_hi_nxt;
  logic                  err_nxt;

  xc_rr_arb2 u_arb (
    .clock  (clock),
    .resetn (resetn),
    .req    ({b_valid, a_valid}),
    .xfer   (accept),
    .grant  (grant)
  );

  // Readys are gated with resetn so nothing is consumed while reset is held.
  assign a_ready = resetn && (state == IDLE) && grant[0];
  assign b_ready = resetn && (state == IDLE) && grant[1];
  assign accept  = (a_valid && a_ready) || (b_valid && b_ready);

  assign sel_wide     = grant[1] ? b_wide     : a_wide;
  assign sel_addr     = grant[1] ? b_addr     : a_addr;
  assign sel_wdata    = grant[1] ? b_wdata    : a_wdata;
  assign sel_wdata_hi = grant[1] ? b_wdata_hi : a_wdata_hi;

  assign busy = (state == SPLIT_HI) || rd_wen;

  always_comb begin
    state_nxt    = state;
    wen_nxt      = 1'b0;
    wide_nxt     = 1'b0;
    addr_nxt     = '0;
    wdata_nxt    = '0;
    wdata_hi_nxt = '0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_wide && sel_addr[0]) begin
            err_nxt = 1'b1;
          end else begin
            wen_nxt   = 1'b1;
            addr_nxt  = sel_addr;
            wdata_nxt = sel_wdata;
            if (sel_wide) begin
              if (WIDE_EN != 0) begin
                wide_nxt     = 1'b1;
                wdata_hi_nxt = sel_wdata_hi;
              end else begin
                state_nxt = SPLIT_HI;
              end
            end
          end
        end
      end
      SPLIT_HI: begin
        wen_nxt   = 1'b1;
        addr_nxt  = {pend_addr, 1'b1};
        wdata_nxt = pend_hi;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      rd_wen      <= 1'b0;
      rd_wide     <= 1'b0;
      rd_addr     <= '0;
      rd_wdata    <= '0;
      rd_wdata_hi <= '0;
      err         <= 1'b0;
      pend_addr   <= '0;
      pend_hi     <= '0;
    end else begin
      state       <= state_nxt;
      rd_wen      <= wen_nxt;
      rd_wide     <= wide_nxt;
      rd_addr     <= addr_nxt;
      rd_wdata    <= wdata_nxt;
      rd_wdata_hi <= wdata_hi_nxt;
      err         <= err_nxt;
      if (accept) begin
        pend_addr <= sel_addr[REG_ADDR_W-1:1];
        pend_hi   <= sel_wdata_hi;
      end
    end
  end

endmodule : xc_rf_wb
`default_nettype wire

// File: tb/tb_xc_rf_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_xc_rf_wb
// Description : Testbench for xc_rf_wb. Two instances run side by side:
//               index 0 has WIDE_EN=1 and index 1 has WIDE_EN=0. Each has its
//               own inputs. A behavioural model predicts the readys and the
//               next-cycle write port for each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xc_rf_wb;

  logic        clock = 1'b0;
  logic        resetn;
  logic        a_valid [2];
  logic        a_ready [2];
  logic        a_wide [2];
  logic [4:0]  a_addr [2];
  logic [31:0] a_wdata [2];
  logic [31:0] a_wdata_hi [2];
  logic        b_valid [2];
  logic        b_ready [2];
  logic        b_wide [2];
  logic [4:0]  b_addr [2];
  logic [31:0] b_wdata [2];
  logic [31:0] b_wdata_hi [2];
  logic        rd_wen [2];
  logic        rd_wide [2];
  logic [4:0]  rd_addr [2];
  logic [31:0] rd_wdata [2];
  logic [31:0] rd_wdata_hi [2];
  logic        err [2];
  logic        busy [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: last grant was B, split high-half pending and its contents.
  bit          m_last_b [2];
  bit          m_split [2];
  logic [4:0]  m_paddr [2];
  logic [31:0] m_phi [2];
  bit          seen_ra [2];
  bit          seen_rb [2];

  always #5 clock = ~clock;

  xc_rf_wb #(.WIDE_EN(1)) dut0 (
    .clock(clock), .resetn(resetn),
    .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_wide(a_wide[0]), .a_addr(a_addr[0]),
    .a_wdata(a_wdata[0]), .a_wdata_hi(a_wdata_hi[0]),
    .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_wide(b_wide[0]), .b_addr(b_addr[0]),
    .b_wdata(b_wdata[0]), .b_wdata_hi(b_wdata_hi[0]),
    .rd_wen(rd_wen[0]), .rd_wide(rd_wide[0]), .rd_addr(rd_addr[0]), .rd_wdata(rd_wdata[0]),
    .rd_wdata_hi(rd_wdata_hi[0]), .err(err[0]), .busy(busy[0])
  );

  xc_rf_wb #(.WIDE_EN(0)) dut1 (
    .clock(clock), .resetn(resetn),
    .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_wide(a_wide[1]), .a_addr(a_addr[1]),
    .a_wdata(a_wdata[1]), .a_wdata_hi(a_wdata_hi[1]),
    .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_wide(b_wide[1]), .b_addr(b_addr[1]),
    .b_wdata(b_wdata[1]), .b_wdata_hi(b_wdata_hi[1]),
    .rd_wen(rd_wen[1]), .rd_wide(rd_wide[1]), .rd_addr(rd_addr[1]), .rd_wdata(rd_wdata[1]),
    .rd_wdata_hi(rd_wdata_hi[1]), .err(err[1]), .busy(busy[1])
  );

  task automatic idle_inputs(int k);
    a_valid[k] = 0; a_wide[k] = 0; a_addr[k] = 0; a_wdata[k] = 0; a_wdata_hi[k] = 0;
    b_valid[k] = 0; b_wide[k] = 0; b_addr[k] = 0; b_wdata[k] = 0; b_wdata_hi[k] = 0;
  endtask

  task automatic set_a(int k, bit w, logic [4:0] ad, logic [31:0] d, logic [31:0] h);
    a_valid[k] = 1; a_wide[k] = w; a_addr[k] = ad; a_wdata[k] = d; a_wdata_hi[k] = h;
  endtask

  task automatic set_b(int k, bit w, logic [4:0] ad, logic [31:0] d, logic [31:0] h);
    b_valid[k] = 1; b_wide[k] = w; b_addr[k] = ad; b_wdata[k] = d; b_wdata_hi[k] = h;
  endtask

  // One clock cycle with the inputs currently driven. The readys are compared
  // before the edge. The write port, err and busy are compared after the edge.
  task automatic run_cycle();
    bit          e_wen [2], e_wide [2], e_err [2], e_busy [2];
    logic [4:0]  e_addr [2];
    logic [31:0] e_d [2], e_dh [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      bit ra, rb, w;
      logic [4:0] ad0;
      logic [31:0] d0, h0;
      ra = 0; rb = 0;
      e_wen[k] = 0; e_wide[k] = 0; e_err[k] = 0; e_addr[k] = 0; e_d[k] = 0; e_dh[k] = 0;
      if (!resetn) begin
        m_last_b[k] = 1;
        m_split[k]  = 0;
      end else if (m_split[k]) begin
        e_wen[k]   = 1;
        e_addr[k]  = m_paddr[k] | 5'd1;
        e_d[k]     = m_phi[k];
        m_split[k] = 0;
      end else begin
        ra = a_valid[k] && (!b_valid[k] || m_last_b[k]);
        rb = b_valid[k] && !ra;
        if (ra || rb) begin
          m_last_b[k] = rb;
          w   = rb ? b_wide[k]     : a_wide[k];
          ad0 = rb ? b_addr[k]     : a_addr[k];
          d0  = rb ? b_wdata[k]    : a_wdata[k];
          h0  = rb ? b_wdata_hi[k] : a_wdata_hi[k];
          if (w && ad0[0]) begin
            e_err[k] = 1;
          end else begin
            e_wen[k] = 1; e_addr[k] = ad0; e_d[k] = d0;
            if (w && k == 0) begin
              e_wide[k] = 1; e_dh[k] = h0;
            end else if (w) begin
              m_split[k] = 1; m_paddr[k] = ad0; m_phi[k] = h0;
            end
          end
        end
      end
      e_busy[k] = e_wen[k] || m_split[k];
      seen_ra[k] = ra; seen_rb[k] = rb;
      n_checks++;
      if (a_ready[k] !== ra || b_ready[k] !== rb) begin
        n_fail++;
        $display("FAIL ready dut%0d: got a=%b b=%b expected a=%b b=%b", k, a_ready[k], b_ready[k], ra, rb);
      end
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (rd_wen[k] !== e_wen[k] || rd_wide[k] !== e_wide[k] || err[k] !== e_err[k] || busy[k] !== e_busy[k]) begin
        n_fail++;
        $display("FAIL ctrl dut%0d: got wen=%b wide=%b err=%b busy=%b expected wen=%b wide=%b err=%b busy=%b",
                 k, rd_wen[k], rd_wide[k], err[k], busy[k], e_wen[k], e_wide[k], e_err[k], e_busy[k]);
      end
      if (e_wen[k] || !resetn) begin
        n_checks++;
        if (rd_addr[k] !== e_addr[k] || rd_wdata[k] !== e_d[k] || rd_wdata_hi[k] !== e_dh[k]) begin
          n_fail++;
          $display("FAIL wdata dut%0d: got addr=%0d d=%h hi=%h expected addr=%0d d=%h hi=%h",
                   k, rd_addr[k], rd_wdata[k], rd_wdata_hi[k], e_addr[k], e_d[k], e_dh[k]);
        end
      end
      if (!rd_wide[k]) begin
        n_checks++;
        if (rd_wdata_hi[k] !== 32'd0) begin
          n_fail++;
          $display("FAIL hi_zero dut%0d: got %h expected 0", k, rd_wdata_hi[k]);
        end
      end
    end
  endtask

  task automatic do_reset();
    idle_inputs(0); idle_inputs(1);
    resetn = 0;
    run_cycle();
    run_cycle();
    resetn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (rd_wen[k] !== 0 || rd_addr[k] !== 0 || rd_wdata[k] !== 0 || err[k] !== 0 || busy[k] !== 0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got wen=%b addr=%0d d=%h err=%b busy=%b expected all 0",
                 k, rd_wen[k], rd_addr[k], rd_wdata[k], err[k], busy[k]);
      end
    end
  endtask

  task automatic test_narrow();
    for (int k = 0; k < 2; k++) set_a(k, 0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
    run_cycle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (!seen_ra[k] || rd_wen[k] !== 1 || rd_addr[k] !== 5'd5 || rd_wdata[k] !== 32'h1234_5678 || rd_wide[k] !== 0) begin
        n_fail++;
        $display("FAIL narrow dut%0d: got wen=%b addr=%0d d=%h wide=%b expected 1 5 12345678 0",
                 k, rd_wen[k], rd_addr[k], rd_wdata[k], rd_wide[k]);
      end
    end
    idle_inputs(0); idle_inputs(1);
    run_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        set_a(k, 0, 5'(2 * i), 32'hA000_0000 + i, 0);
        set_b(k, 0, 5'(2 * i + 1), 32'hB000_0000 + i, 0);
      end
      run_cycle();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (seen_ra[k] != (i % 2 == 0) || rd_wen[k] !== 1) begin
          n_fail++;
          $display("FAIL tie_grant dut%0d cyc%0d: got a_acc=%b wen=%b expected a_acc=%b wen=1",
                   k, i, seen_ra[k], rd_wen[k], (i % 2 == 0));
        end
      end
    end
    idle_inputs(0); idle_inputs(1);
    run_cycle();
  endtask

  task automatic test_wide();
    for (int k = 0; k < 2; k++) set_b(k, 1, 5'd6, 32'hAAAA_0000, 32'hBBBB_1111);
    run_cycle();
    n_checks++;
    if (rd_wide[0] !== 1 || rd_addr[0] !== 5'd6 || rd_wdata_hi[0] !== 32'hBBBB_1111) begin
      n_fail++;
      $display("FAIL wide_native: got wide=%b addr=%0d hi=%h expected 1 6 bbbb1111", rd_wide[0], rd_addr[0], rd_wdata_hi[0]);
    end
    n_checks++;
    if (rd_wide[1] !== 0 || rd_addr[1] !== 5'd6 || rd_wdata[1] !== 32'hAAAA_0000 || busy[1] !== 1) begin
      n_fail++;
      $display("FAIL split_lo: got wide=%b addr=%0d d=%h busy=%b expected 0 6 aaaa0000 1", rd_wide[1], rd_addr[1], rd_wdata[1], busy[1]);
    end
    idle_inputs(0); idle_inputs(1);
    set_a(1, 0, 5'd9, 32'h9999_9999, 0);
    run_cycle();
    n_checks++;
    if (seen_ra[1] || rd_addr[1] !== 5'd7 || rd_wdata[1] !== 32'hBBBB_1111 || busy[1] !== 1 || rd_wide[1] !== 0) begin
      n_fail++;
      $display("FAIL split_hi: got a_acc=%b addr=%0d d=%h busy=%b wide=%b expected 0 7 bbbb1111 1 0",
               seen_ra[1], rd_addr[1], rd_wdata[1], busy[1], rd_wide[1]);
    end
    run_cycle();
    idle_inputs(0); idle_inputs(1);
    run_cycle();
  endtask

  task automatic test_odd_wide();
    for (int k = 0; k < 2; k++) set_a(k, 1, 5'd3, 32'h3333_3333, 32'h4444_4444);
    run_cycle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (!seen_ra[k] || err[k] !== 1 || rd_wen[k] !== 0) begin
        n_fail++;
        $display("FAIL odd_wide dut%0d: got acc=%b err=%b wen=%b expected 1 1 0", k, seen_ra[k], err[k], rd_wen[k]);
      end
    end
    idle_inputs(0); idle_inputs(1);
    run_cycle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (err[k] !== 0) begin
        n_fail++;
        $display("FAIL err_pulse dut%0d: got %b expected 0", k, err[k]);
      end
    end
  endtask

  task automatic test_reset_split();
    set_b(1, 1, 5'd6, 32'hAAAA_0000, 32'hBBBB_1111);
    run_cycle();
    idle_inputs(1);
    resetn = 0;
    run_cycle();
    resetn = 1;
    run_cycle();
    n_checks++;
    if (rd_wen[1] !== 0 || rd_addr[1] !== 0 || busy[1] !== 0) begin
      n_fail++;
      $display("FAIL reset_split: got wen=%b addr=%0d busy=%b expected 0 0 0", rd_wen[1], rd_addr[1], busy[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      resetn = ($urandom_range(0, 59) != 0);
      for (int k = 0; k < 2; k++) begin
        idle_inputs(k);
        if ($urandom_range(0, 3) != 0)
          set_a(k, ($urandom_range(0, 2) == 0), 5'($urandom), $urandom, $urandom);
        if ($urandom_range(0, 3) != 0)
          set_b(k, ($urandom_range(0, 2) == 0), 5'($urandom), $urandom, $urandom);
      end
      run_cycle();
    end
    resetn = 1;
  endtask

  initial begin
    m_last_b[0] = 1; m_last_b[1] = 1;
    m_split[0] = 0; m_split[1] = 0;
    resetn = 0;
    idle_inputs(0); idle_inputs(1);
    test_reset();
    test_narrow();
    test_back_to_back();
    test_wide();
    test_odd_wide();
    test_reset_split();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_xc_rf_wb
`default_nettype wire
